fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Read-side consumer of the team's 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO's rd/empty/data_out interface and serialises it onto an asynchronous serial TX line: start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits.
- Sits between the FIFO output and the chip pad.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
- PARITY_EN, 0, 1 = append an even-parity bit after the data bits; 0 = no parity bit.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  FIFO read strobe; one-cycle pulse per byte.
- fifo_data  in  8  FIFO data_out; valid the cycle after the fifo_rd cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when the final stop bit completes.
- frames_sent  out  16  count of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE; tx=1; fifo_rd=0; busy=0; frame_done=0; frames_sent=0.
  - Baud counter, bit counter and shift register cleared.
- All outputs are registered or pure Moore decodes of state. No combinational path from inputs to outputs.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0 at the clock edge -> POP; otherwise stay.
- POP: exactly one cycle; fifo_rd=1 only in this state. Next state LOAD unconditionally. fifo_empty is not re-checked (this block is the only reader, so the FIFO cannot drain underneath it).
- LOAD: one cycle. Capture fifo_data into the shift register, compute parity (XOR of all 8 bits), then -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - tx = shift register bit 0 for CLKS_PER_BIT cycles per bit, then shift right.
  - After 8 bits -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles -> STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle: frame_done=1 for exactly that cycle, frames_sent increments, next state IDLE.
- Frame length on the wire: (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Back-to-back frames: minimum gap of exactly 3 cycles of tx=1 (IDLE, POP, LOAD) between the end of a stop bit and the next start bit.
- Latency: from the IDLE cycle in which enable=1 and fifo_empty=0, the start bit begins 3 cycles later.
- enable deasserted mid-frame: the current frame completes normally; no further pop occurs.
- Reset asserted mid-frame: tx returns to 1 immediately and the in-flight byte is discarded. After release, the next frame uses the next FIFO byte.
- Baud counter width: clog2(CLKS_PER_BIT). Bit counter: 3 bits.
- frames_sent: plain 16-bit wrap-around increment, no saturation.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset: drive rst=0 mid-run with the clock stopped -> tx=1, fifo_rd=0, busy=0, frame_done=0, frames_sent=0 without any clock edge.
- Single byte 0xA5, PARITY_EN=0, STOP_BITS=1:
  - Exactly one fifo_rd pulse.
  - tx sequence of 4-cycle bits: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - frame_done pulses on the 40th tx cycle; frames_sent=1.
- Three preloaded bytes 0x00, 0xFF, 0x3C:
  - Three fifo_rd pulses.
  - Exactly 3 idle-high cycles between each stop bit and the next start bit.
  - frames_sent=3.
  - busy drops only after the third frame.
- PARITY_EN=1, STOP_BITS=2, byte 0x07 -> data bits 1,1,1,0,0,0,0,0; parity bit 1; then 8 cycles of tx=1; frame length 48 cycles.
- enable=0 with fifo_empty=0 for 100 cycles -> no fifo_rd and tx=1 throughout. Then set enable=1 and clear it during the DATA state -> that frame completes and no second pop occurs.
- rst pulsed low during the DATA state of byte 0x55 (0x66 queued next) -> tx=1 immediately. After release with enable=1, the next frame transmits 0x66; frames_sent counts from 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Read-side FIFO consumer that serialises each popped byte onto an async TX line:
// start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [7:0]  fifo_data,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_reg;
  logic [7:0]        shift_reg;
  logic              parity_reg;
  logic [15:0]       frames_reg;
  logic              baud_last;

  assign baud_last = (baud_reg == BAUD_LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      frames_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_reg <= '0;
          bit_reg  <= '0;
          if (enable && !fifo_empty) state_reg <= POP;
        end
        // This block is the only reader, so the FIFO cannot drain between IDLE and POP.
        POP: state_reg <= LOAD;
        LOAD: begin
          shift_reg  <= fifo_data;
          parity_reg <= ^fifo_data;
          baud_reg   <= '0;
          bit_reg    <= '0;
          state_reg  <= START;
        end
        START: begin
          if (baud_last) begin
            baud_reg  <= '0;
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_reg == 3'd7) begin
              bit_reg   <= '0;
              state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_reg  <= '0;
            state_reg <= STOP;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        STOP: begin
          // bit_reg counts stop bits here; the frame ends on the last cycle of the last one.
          if (baud_last) begin
            baud_reg <= '0;
            if (bit_reg == STOP_LAST) begin
              bit_reg    <= '0;
              frames_reg <= frames_reg + 16'd1;
              state_reg  <= IDLE;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset forces them without a clock edge.
  always_comb begin
    tx = 1'b1;
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      PARITY:  tx = parity_reg;
      default: tx = 1'b1;
    endcase
  end

  assign fifo_rd     = (state_reg == POP);
  assign busy        = (state_reg != IDLE);
  assign frame_done  = (state_reg == STOP) && baud_last && (bit_reg == STOP_LAST);
  assign frames_sent = frames_reg;

endmodule
